// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg
// Shared definitions for the data-side memory controller:
//   - state_t   : controller FSM state encoding
//   - SZ_B/H/W  : LOAD_SIZE codes (2'b11 is treated as a word)
package data_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_REQ  = 3'd1,
    LD_REQ  = 3'd2,
    LD_WAIT = 3'd3,
    LD_DONE = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if
// Data bus between the controller (master) and the memory (slave).
//
// Handshake: the master raises MEM_REQ together with MEM_WE/MEM_ADDR/
// MEM_STRB/MEM_WDATA, and holds all of them stable until a cycle in which
// the slave drives MEM_GNT=1; the request transfers at the clock edge ending
// that cycle. Writes are posted (no response). For a read, the slave
// returns MEM_RDATA with a one-cycle MEM_RVALID pulse no earlier than the
// cycle after the grant; there is no back-pressure on read data.
//
// Signals:
//   MEM_REQ    master->slave  bus request
//   MEM_WE     master->slave  1 write, 0 read
//   MEM_ADDR   master->slave  word-aligned byte address
//   MEM_STRB   master->slave  write byte lanes (4'b1111 on reads)
//   MEM_WDATA  master->slave  write data
//   MEM_GNT    slave->master  request accepted this cycle
//   MEM_RVALID slave->master  read data valid
//   MEM_RDATA  slave->master  read data
interface data_mem_ctrl_if;

  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_STRB;
  logic [31:0] MEM_WDATA;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
    input  MEM_GNT, MEM_RVALID, MEM_RDATA
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
    output MEM_GNT, MEM_RVALID, MEM_RDATA
  );

endinterface

// File: rtl/data_mem_ctrl_load_align.sv
// data_mem_ctrl_load_align
// Purely combinational load formatter: picks the addressed lane(s) out of a
// 32-bit bus word, right-justifies them and sign- or zero-extends.
//
// Ports:
//   rdata     in  32  raw bus read data
//   sel       in  2   byte offset (addr[1:0])
//   size      in  2   SZ_B / SZ_H / SZ_W (2'b11 = word)
//   is_signed in  1   1 sign-extend, 0 zero-extend
//   result    out 32  formatted load data
module data_mem_ctrl_load_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  sel,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    lane8 = rdata[7:0];
    case (sel)
      2'd0: lane8 = rdata[7:0];
      2'd1: lane8 = rdata[15:8];
      2'd2: lane8 = rdata[23:16];
      2'd3: lane8 = rdata[31:24];
      default: lane8 = rdata[7:0];
    endcase

    // Halfwords pick a lane pair by sel[1] only; misaligned halves are not
    // split across words.
    lane16 = sel[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    case (size)
      SZ_B: result = is_signed ? {{24{lane8[7]}}, lane8} : {24'd0, lane8};
      SZ_H: result = is_signed ? {{16{lane16[15]}}, lane16} : {16'd0, lane16};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Data-side memory controller for the RV32I pipeline. Captures one load or
// store from the ALU stage while idle, runs it on the request/grant/response
// bus and returns formatted load data. STALL holds the pipeline until the
// access completes; in LD_DONE the stage forwards DATA_RDDATA and advances.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   FLUSH                    drop a request presented this cycle
//   LOAD_RDEN/ADDR/SIZE/SIGNED   load request from the ALU stage
//   STORE_WREN/ADDR/STRB/DATA    store request (lane-aligned)
//   STALL                    pipeline hold
//   DATA_RDVALID/RDDATA      formatted load result, one-cycle valid
//   DBG_STATE                current FSM state
//   mem                      data bus, master side
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        LOAD_RDEN,
  input  logic [31:0] LOAD_ADDR,
  input  logic [1:0]  LOAD_SIZE,
  input  logic        LOAD_SIGNED,
  input  logic        STORE_WREN,
  input  logic [31:0] STORE_ADDR,
  input  logic [3:0]  STORE_STRB,
  input  logic [31:0] STORE_DATA,
  output logic        STALL,
  output logic        DATA_RDVALID,
  output logic [31:0] DATA_RDDATA,
  output state_t      DBG_STATE,
  data_mem_ctrl_if.master mem
);

  state_t      state;
  logic [1:0]  ld_sel;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [31:0] ld_result;

  assign DBG_STATE = state;

  data_mem_ctrl_load_align u_load_align (
    .rdata     (mem.MEM_RDATA),
    .sel       (ld_sel),
    .size      (ld_size),
    .is_signed (ld_signed),
    .result    (ld_result)
  );

  // All outputs are registered. MEM_* are loaded once at capture and only
  // change again when the grant is seen, so they are stable while waiting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      STALL         <= 1'b0;
      DATA_RDVALID  <= 1'b0;
      DATA_RDDATA   <= 32'd0;
      mem.MEM_REQ   <= 1'b0;
      mem.MEM_WE    <= 1'b0;
      mem.MEM_ADDR  <= 32'd0;
      mem.MEM_STRB  <= 4'd0;
      mem.MEM_WDATA <= 32'd0;
      ld_sel        <= 2'd0;
      ld_size       <= 2'd0;
      ld_signed     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DATA_RDVALID <= 1'b0;
          if (!FLUSH) begin
            // Store has priority; a simultaneous load is dropped.
            if (STORE_WREN) begin
              state         <= ST_REQ;
              STALL         <= 1'b1;
              mem.MEM_REQ   <= 1'b1;
              mem.MEM_WE    <= 1'b1;
              mem.MEM_ADDR  <= {STORE_ADDR[31:2], 2'b00};
              mem.MEM_STRB  <= STORE_STRB;
              mem.MEM_WDATA <= STORE_DATA;
            end else if (LOAD_RDEN) begin
              state         <= LD_REQ;
              STALL         <= 1'b1;
              mem.MEM_REQ   <= 1'b1;
              mem.MEM_WE    <= 1'b0;
              mem.MEM_ADDR  <= {LOAD_ADDR[31:2], 2'b00};
              mem.MEM_STRB  <= 4'b1111;
              ld_sel        <= LOAD_ADDR[1:0];
              ld_size       <= LOAD_SIZE;
              ld_signed     <= LOAD_SIGNED;
            end
          end
        end

        ST_REQ: begin
          if (mem.MEM_GNT) begin
            state       <= IDLE;
            STALL       <= 1'b0;
            mem.MEM_REQ <= 1'b0;
            mem.MEM_WE  <= 1'b0;
          end
        end

        LD_REQ: begin
          if (mem.MEM_GNT) begin
            state       <= LD_WAIT;
            mem.MEM_REQ <= 1'b0;
          end
        end

        // Only reached the cycle after grant, so RVALID in the grant
        // cycle is never sampled.
        LD_WAIT: begin
          if (mem.MEM_RVALID) begin
            state        <= LD_DONE;
            STALL        <= 1'b0;
            DATA_RDVALID <= 1'b1;
            DATA_RDDATA  <= ld_result;
          end
        end

        // No capture here: the stage is consuming this load's data.
        LD_DONE: begin
          state        <= IDLE;
          DATA_RDVALID <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          STALL        <= 1'b0;
          DATA_RDVALID <= 1'b0;
          mem.MEM_REQ  <= 1'b0;
          mem.MEM_WE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl: reset values, zero-wait and delayed
// loads, lane formatting corners, stores, store/load priority, FLUSH and
// reset during an outstanding load.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        FLUSH;
  logic        LOAD_RDEN;
  logic [31:0] LOAD_ADDR;
  logic [1:0]  LOAD_SIZE;
  logic        LOAD_SIGNED;
  logic        STORE_WREN;
  logic [31:0] STORE_ADDR;
  logic [3:0]  STORE_STRB;
  logic [31:0] STORE_DATA;
  logic        STALL;
  logic        DATA_RDVALID;
  logic [31:0] DATA_RDDATA;
  state_t      DBG_STATE;

  data_mem_ctrl_if mem_if ();

  data_mem_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .FLUSH        (FLUSH),
    .LOAD_RDEN    (LOAD_RDEN),
    .LOAD_ADDR    (LOAD_ADDR),
    .LOAD_SIZE    (LOAD_SIZE),
    .LOAD_SIGNED  (LOAD_SIGNED),
    .STORE_WREN   (STORE_WREN),
    .STORE_ADDR   (STORE_ADDR),
    .STORE_STRB   (STORE_STRB),
    .STORE_DATA   (STORE_DATA),
    .STALL        (STALL),
    .DATA_RDVALID (DATA_RDVALID),
    .DATA_RDDATA  (DATA_RDDATA),
    .DBG_STATE    (DBG_STATE),
    .mem          (mem_if)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- helpers ----------------
  // Advance to 1 time unit after the next rising edge; inputs are driven
  // and outputs sampled there.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    FLUSH       = 1'b0;
    LOAD_RDEN   = 1'b0;
    STORE_WREN  = 1'b0;
    mem_if.MEM_GNT    = 1'b0;
    mem_if.MEM_RVALID = 1'b0;
  endtask

  // Zero-wait load: capture at edge 0, GNT in cycle 1, RVALID in cycle 2,
  // result in cycle 3. RVALID is also pulsed in the grant cycle with junk
  // data, which must be ignored.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
    LOAD_RDEN = 1'b1; LOAD_ADDR = addr; LOAD_SIZE = size; LOAD_SIGNED = sgn;
    tick();                                     // cycle 1
    LOAD_RDEN = 1'b0;
    chk({tag, "/req_c1"},   32'(mem_if.MEM_REQ), 32'd1);
    chk({tag, "/addr_c1"},  mem_if.MEM_ADDR, {addr[31:2], 2'b00});
    chk({tag, "/stall_c1"}, 32'(STALL), 32'd1);
    mem_if.MEM_GNT = 1'b1; mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = 32'hDEAD_BEEF;
    tick();                                     // cycle 2
    chk({tag, "/stall_c2"}, 32'(STALL), 32'd1);
    chk({tag, "/rdv_c2"},   32'(DATA_RDVALID), 32'd0);
    mem_if.MEM_GNT = 1'b0; mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = rdata;
    tick();                                     // cycle 3
    mem_if.MEM_RVALID = 1'b0;
    chk({tag, "/rdv_c3"},   32'(DATA_RDVALID), 32'd1);
    chk({tag, "/data_c3"},  DATA_RDDATA, exp);
    chk({tag, "/stall_c3"}, 32'(STALL), 32'd0);
    tick();                                     // cycle 4, IDLE
    chk({tag, "/rdv_c4"},   32'(DATA_RDVALID), 32'd0);
    chk({tag, "/state_c4"}, 32'(DBG_STATE), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RST = 1'b1;
    idle_inputs();
    LOAD_ADDR = '0; LOAD_SIZE = '0; LOAD_SIGNED = 1'b0;
    STORE_ADDR = '0; STORE_STRB = '0; STORE_DATA = '0;
    mem_if.MEM_RDATA = '0;
    tick();
    tick();

    // Reset values
    chk("rst/state",  32'(DBG_STATE), 32'(IDLE));
    chk("rst/stall",  32'(STALL), 32'd0);
    chk("rst/rdv",    32'(DATA_RDVALID), 32'd0);
    chk("rst/rddata", DATA_RDDATA, 32'd0);
    chk("rst/req",    32'(mem_if.MEM_REQ), 32'd0);
    chk("rst/we",     32'(mem_if.MEM_WE), 32'd0);
    chk("rst/addr",   mem_if.MEM_ADDR, 32'd0);
    chk("rst/strb",   32'(mem_if.MEM_STRB), 32'd0);
    chk("rst/wdata",  mem_if.MEM_WDATA, 32'd0);
    RST = 1'b0;
    tick();

    // LB signed, lane 3 = 0x80
    do_load("lb_s", 32'h0000_0103, SZ_B, 1'b1, 32'h8011_2233, 32'hFFFF_FF80);
    // LBU same lane
    do_load("lbu", 32'h0000_0103, SZ_B, 1'b0, 32'h8011_2233, 32'h0000_0080);
    // LBU lane 2
    do_load("lbu2", 32'h0000_0002, SZ_B, 1'b0, 32'h8011_2233, 32'h0000_0011);
    // LH signed, misaligned addr 1 -> sel[0] ignored, low half
    do_load("lh_mis", 32'h0000_0001, SZ_H, 1'b1, 32'h1234_8001, 32'hFFFF_8001);
    // size 11 treated as word, misaligned sel ignored
    do_load("lw_11", 32'h0000_0007, 2'b11, 1'b1, 32'h89AB_CDEF, 32'h89AB_CDEF);

    // LHU with grant delayed 3 cycles, RVALID 2 cycles after grant
    LOAD_RDEN = 1'b1; LOAD_ADDR = 32'h0000_0202; LOAD_SIZE = SZ_H; LOAD_SIGNED = 1'b0;
    tick();                                     // cycle 1
    LOAD_RDEN = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("lhu/req_held",   32'(mem_if.MEM_REQ), 32'd1);
      chk("lhu/we_held",    32'(mem_if.MEM_WE), 32'd0);
      chk("lhu/addr_held",  mem_if.MEM_ADDR, 32'h0000_0200);
      chk("lhu/strb_held",  32'(mem_if.MEM_STRB), 32'hF);
      chk("lhu/stall_held", 32'(STALL), 32'd1);
      tick();
    end
    mem_if.MEM_GNT = 1'b1;                      // cycle 4: grant
    chk("lhu/req_c4", 32'(mem_if.MEM_REQ), 32'd1);
    tick();                                     // cycle 5
    mem_if.MEM_GNT = 1'b0;
    chk("lhu/req_c5",   32'(mem_if.MEM_REQ), 32'd0);
    chk("lhu/stall_c5", 32'(STALL), 32'd1);
    chk("lhu/state_c5", 32'(DBG_STATE), 32'(LD_WAIT));
    tick();                                     // cycle 6
    chk("lhu/stall_c6", 32'(STALL), 32'd1);
    mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = 32'hBEEF_1234;
    tick();                                     // cycle 7, LD_DONE
    mem_if.MEM_RVALID = 1'b0;
    chk("lhu/rdv",   32'(DATA_RDVALID), 32'd1);
    chk("lhu/data",  DATA_RDDATA, 32'h0000_BEEF);
    chk("lhu/stall", 32'(STALL), 32'd0);
    // A store offered in LD_DONE must be ignored.
    STORE_WREN = 1'b1; STORE_ADDR = 32'h0000_0700; STORE_STRB = 4'hF; STORE_DATA = 32'h1;
    tick();                                     // cycle 8
    STORE_WREN = 1'b0;
    chk("lddone_ign/req",   32'(mem_if.MEM_REQ), 32'd0);
    chk("lddone_ign/state", 32'(DBG_STATE), 32'(IDLE));
    chk("lddone_ign/rdv",   32'(DATA_RDVALID), 32'd0);
    tick();

    // SB, lane 2
    STORE_WREN = 1'b1; STORE_ADDR = 32'h0000_0305; STORE_STRB = 4'b0100; STORE_DATA = 32'h00AB_0000;
    tick();                                     // cycle 1
    STORE_WREN = 1'b0;
    chk("sb/req",   32'(mem_if.MEM_REQ), 32'd1);
    chk("sb/we",    32'(mem_if.MEM_WE), 32'd1);
    chk("sb/strb",  32'(mem_if.MEM_STRB), 32'h4);
    chk("sb/addr",  mem_if.MEM_ADDR, 32'h0000_0304);
    chk("sb/wdata", mem_if.MEM_WDATA, 32'h00AB_0000);
    chk("sb/stall", 32'(STALL), 32'd1);
    mem_if.MEM_GNT = 1'b1;
    tick();                                     // cycle 2
    mem_if.MEM_GNT = 1'b0;
    chk("sb/req_c2",   32'(mem_if.MEM_REQ), 32'd0);
    chk("sb/stall_c2", 32'(STALL), 32'd0);
    chk("sb/rdv_c2",   32'(DATA_RDVALID), 32'd0);
    chk("sb/state_c2", 32'(DBG_STATE), 32'(IDLE));

    // Load and store together: store wins (captured at edge ending cycle 2)
    STORE_WREN = 1'b1; STORE_ADDR = 32'h0000_0400; STORE_STRB = 4'hF; STORE_DATA = 32'h1234_5678;
    LOAD_RDEN  = 1'b1; LOAD_ADDR  = 32'h0000_0500; LOAD_SIZE  = SZ_W; LOAD_SIGNED = 1'b0;
    tick();
    STORE_WREN = 1'b0; LOAD_RDEN = 1'b0;
    chk("both/we",    32'(mem_if.MEM_WE), 32'd1);
    chk("both/addr",  mem_if.MEM_ADDR, 32'h0000_0400);
    chk("both/wdata", mem_if.MEM_WDATA, 32'h1234_5678);
    mem_if.MEM_GNT = 1'b1;
    tick();
    mem_if.MEM_GNT = 1'b0;
    chk("both/req_after", 32'(mem_if.MEM_REQ), 32'd0);
    tick();
    chk("both/no_read_req",   32'(mem_if.MEM_REQ), 32'd0);
    chk("both/no_read_state", 32'(DBG_STATE), 32'(IDLE));

    // FLUSH with a load in IDLE: dropped
    FLUSH = 1'b1; LOAD_RDEN = 1'b1; LOAD_ADDR = 32'h0000_0600;
    tick();
    FLUSH = 1'b0; LOAD_RDEN = 1'b0;
    chk("flush_idle/req",   32'(mem_if.MEM_REQ), 32'd0);
    chk("flush_idle/stall", 32'(STALL), 32'd0);
    tick();
    chk("flush_idle/req2",  32'(mem_if.MEM_REQ), 32'd0);

    // FLUSH during LD_WAIT: load still completes
    LOAD_RDEN = 1'b1; LOAD_ADDR = 32'h0000_0000; LOAD_SIZE = SZ_W; LOAD_SIGNED = 1'b1;
    tick();                                     // cycle 1
    LOAD_RDEN = 1'b0;
    mem_if.MEM_GNT = 1'b1;
    tick();                                     // cycle 2, LD_WAIT
    mem_if.MEM_GNT = 1'b0;
    FLUSH = 1'b1;
    tick();                                     // cycle 3, still waiting
    chk("flush_wait/stall", 32'(STALL), 32'd1);
    chk("flush_wait/state", 32'(DBG_STATE), 32'(LD_WAIT));
    FLUSH = 1'b0;
    mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = 32'hCAFE_F00D;
    tick();                                     // cycle 4
    mem_if.MEM_RVALID = 1'b0;
    chk("flush_wait/rdv",  32'(DATA_RDVALID), 32'd1);
    chk("flush_wait/data", DATA_RDDATA, 32'hCAFE_F00D);
    tick();

    // Reset during LD_WAIT, then a late RVALID
    LOAD_RDEN = 1'b1; LOAD_ADDR = 32'h0000_0010; LOAD_SIZE = SZ_W; LOAD_SIGNED = 1'b0;
    tick();                                     // cycle 1
    LOAD_RDEN = 1'b0;
    mem_if.MEM_GNT = 1'b1;
    tick();                                     // cycle 2, LD_WAIT
    mem_if.MEM_GNT = 1'b0;
    chk("rst_wait/pre_state", 32'(DBG_STATE), 32'(LD_WAIT));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_wait/state",  32'(DBG_STATE), 32'(IDLE));
    chk("rst_wait/req",    32'(mem_if.MEM_REQ), 32'd0);
    chk("rst_wait/stall",  32'(STALL), 32'd0);
    chk("rst_wait/rddata", DATA_RDDATA, 32'd0);
    chk("rst_wait/addr",   mem_if.MEM_ADDR, 32'd0);
    chk("rst_wait/strb",   32'(mem_if.MEM_STRB), 32'd0);
    mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = 32'h5555_AAAA;
    tick();
    mem_if.MEM_RVALID = 1'b0;
    chk("rst_wait/rdv_late",   32'(DATA_RDVALID), 32'd0);
    chk("rst_wait/state_late", 32'(DBG_STATE), 32'(IDLE));
    chk("rst_wait/data_late",  DATA_RDDATA, 32'd0);
    tick();
    chk("rst_wait/rdv_late2",  32'(DATA_RDVALID), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
